// File: rtl/program_loader.sv
// program_loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory and holds the core in reset until the whole image has been loaded.
module program_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    output logic              done,
    output logic              err,
    output logic [7:0]        illegal_cnt,
    output logic [ADDR_W-1:0] first_bad
);
    typedef enum logic [1:0] {HDR, LOAD, DONE, ERR} state_t;
    localparam logic [31:0] CAP = 32'(1) << ADDR_W;
    state_t          state;
    logic [1:0]      byte_idx;
    logic [23:0]     partial;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] cnt;
    logic [31:0]     word;
    logic            fire;
    logic            last;
    logic            legal;
    assign fire  = in_valid & in_ready;
    assign last  = fire && byte_idx == 2'd3;
    assign word  = {in_data, partial};
    assign legal = word[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                                     7'b0010011, 7'b1101111, 7'b1100111, 7'b1010011};
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= HDR;
            in_ready    <= 1'b1;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            core_rstn   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            illegal_cnt <= '0;
            first_bad   <= '0;
            byte_idx    <= '0;
            partial     <= '0;
            idx         <= '0;
            cnt         <= '0;
        end else begin
            imem_we <= 1'b0;
            if (fire) begin
                byte_idx <= byte_idx + 2'd1;
                partial  <= {in_data, partial[23:8]};
            end
            case (state)
                HDR: if (last) begin
                    if (word == 32'd0) begin
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        done      <= 1'b1;
                        core_rstn <= 1'b1;
                    end else if (word > CAP) begin
                        state    <= ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        state <= LOAD;
                        cnt   <= word[ADDR_W:0];
                        idx   <= '0;
                    end
                end
                LOAD: if (last) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= idx[ADDR_W-1:0];
                    imem_wdata <= word;
                    idx        <= idx + (ADDR_W+1)'(1);
                    if (!legal) begin
                        if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
                        if (illegal_cnt == 8'd0) first_bad <= idx[ADDR_W-1:0];
                    end
                    if (idx + (ADDR_W+1)'(1) == cnt) begin
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        done      <= 1'b1;
                        core_rstn <= 1'b1;
                    end
                end
                DONE: if (start) begin
                    state       <= HDR;
                    in_ready    <= 1'b1;
                    done        <= 1'b0;
                    core_rstn   <= 1'b0;
                    illegal_cnt <= '0;
                    first_bad   <= '0;
                    idx         <= '0;
                end
                ERR: if (start) begin
                    state    <= HDR;
                    in_ready <= 1'b1;
                    err      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized loads through a byte-level driver, with a scoreboard
// monitor comparing every imem write against words the stimulus queued as expected.
module tb_program_loader;
    localparam int AW = 4;
    localparam int CAPW = 1 << AW;
    logic          clk = 0, rstn = 0, in_valid = 0, start = 0;
    logic [7:0]    in_data = 0;
    logic          in_ready, imem_we, core_rstn, done, err;
    logic [AW-1:0] imem_addr, first_bad;
    logic [31:0]   imem_wdata;
    logic [7:0]    illegal_cnt;

    program_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rstn(core_rstn), .done(done), .err(err), .illegal_cnt(illegal_cnt),
        .first_bad(first_bad)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;
    wr_t         exp_q[$];
    wr_t         e_m;
    logic [31:0] prog[$];
    logic [6:0]  legal_ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                                  7'b0010011, 7'b1101111, 7'b1100111, 7'b1010011};
    int total = 0, bad = 0, nwrites = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] w);
        foreach (legal_ops[i]) if (w[6:0] == legal_ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) if (rstn && imem_we) begin
        nwrites++;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
        end else begin
            e_m = exp_q.pop_front();
            chk("wr_addr", 64'(imem_addr), 64'(e_m.a));
            chk("wr_data", 64'(imem_wdata), 64'(e_m.d));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gmax);
        int g;
        g = gmax > 0 ? int'($urandom_range(gmax, 0)) : 0;
        repeat (g) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax, input bit push, input int addr);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && push) exp_q.push_back('{a: AW'(addr), d: w});
            send_byte(w[8*i +: 8], gmax);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends a header of n followed by prog, then checks the end state against the model.
    task automatic run_load(input logic [31:0] n, input int gmax);
        int w0, ill, fb;
        bit e;
        w0 = nwrites;
        ill = 0;
        fb = 0;
        e = n > 32'(CAPW);
        send_word(n, gmax, 1'b0, 0);
        if (!e) foreach (prog[i]) begin
            if (!is_legal(prog[i])) begin
                if (ill == 0) fb = i;
                ill++;
            end
            send_word(prog[i], gmax, 1'b1, i);
        end
        for (int i = 0; i < 100 && !(done || err); i++) @(negedge clk);
        @(negedge clk);
        chk("done", 64'(done), 64'(!e));
        chk("err", 64'(err), 64'(e));
        chk("core_rstn", 64'(core_rstn), 64'(!e));
        chk("in_ready_end", 64'(in_ready), 64'd0);
        chk("write_count", 64'(nwrites - w0), e ? 64'd0 : 64'(n));
        chk("queue_left", 64'(exp_q.size()), 64'd0);
        chk("illegal_cnt", 64'(illegal_cnt), 64'(ill));
        if (ill > 0) chk("first_bad", 64'(first_bad), 64'(fb));
        pulse_start();
        chk("restart", 64'({done, err, core_rstn, in_ready, illegal_cnt}), 64'h1_00);
    endtask

    task automatic chk_reset(input string name);
        chk(name, 64'({in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, err, illegal_cnt, first_bad}),
            64'({1'b1, 52'd0}));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset_values");
        rstn = 1'b1;
        pulse_start();
        chk("start_in_hdr_ignored", 64'({in_ready, done, err}), 64'b100);

        prog = '{32'h13, 32'h6F};
        run_load(2, 0);
        prog = '{};
        run_load(0, 0);
        run_load(17, 0);
        prog = '{32'h13, 32'hFFFF_FFFF, 32'h33};
        run_load(3, 0);

        prog = '{};
        for (int i = 0; i < 8; i++) prog.push_back({$urandom_range(32'h1FF_FFFF, 0), legal_ops[$urandom_range(7, 0)]});
        run_load(8, 0);
        run_load(8, 5);

        prog = '{};
        for (int i = 0; i < CAPW; i++) prog.push_back($urandom);
        run_load(32'(CAPW), 1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(CAPW, 1);
            prog = '{};
            for (int i = 0; i < n; i++)
                prog.push_back($urandom_range(3, 0) == 0 ? 32'($urandom)
                               : {$urandom_range(32'h1FF_FFFF, 0), legal_ops[$urandom_range(7, 0)]});
            run_load(32'(n), $urandom_range(3, 0));
        end

        send_word(32'd2, 0, 1'b0, 0);
        send_word(32'h0000_0013, 0, 1'b1, 0);
        send_byte(8'h6F, 0);
        send_byte(8'h00, 0);
        #2 rstn = 1'b0;
        #1 chk_reset("async_reset_mid_load");
        @(negedge clk);
        rstn = 1'b1;
        chk("queue_after_reset", 64'(exp_q.size()), 64'd0);
        prog = '{32'h0000_0067};
        run_load(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
